// File: rtl/cpu_halt_ctrl.sv
// cpu_halt_ctrl: debounced run/halt sequencer with CPU halt handshake; optional single-step build via SINGLE_STEP_EN
module cpu_halt_ctrl_debounce #(
  parameter int CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic press
);
  localparam int CW = $clog2(CYCLES + 1);
  logic s1_q, s2_q, db_q, db_old_q, press_q;
  logic db_d;
  logic [CW-1:0] cnt_q, cnt_d, inc;
  assign inc = cnt_q + CW'(1);
  // accept a new level only after it has disagreed with the debounced one for CYCLES samples
  always_comb begin
    db_d = (s2_q != db_q && inc == CW'(CYCLES)) ? s2_q : db_q;
    cnt_d = (s2_q == db_q || inc == CW'(CYCLES)) ? '0 : inc;
  end
  // synchroniser, debounce state and a registered rising-edge pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      db_q <= 1'b0;
      db_old_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q <= raw;
      s2_q <= s1_q;
      db_q <= db_d;
      db_old_q <= db_q;
      press_q <= db_q & ~db_old_q;
      cnt_q <= cnt_d;
    end
  end
  assign press = press_q;
endmodule

module cpu_halt_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ACK_TIMEOUT = 64,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic halt_button,
  input  logic step_button,
  input  logic cpu_halt_ack,
  input  logic instr_retired,
  output logic cpu_halt_req,
  output logic cpu_run_en,
  output logic halted,
  output logic timeout_err,
  output logic [CNT_W-1:0] halt_count
);
  localparam int TW = (ACK_TIMEOUT > 2) ? $clog2(ACK_TIMEOUT) : 1;
`ifdef SINGLE_STEP_EN
  typedef enum logic [2:0] {RUN, HALT_REQ, HALTED, RESUME, STEP} state_t;
`else
  typedef enum logic [1:0] {RUN, HALT_REQ, HALTED, RESUME} state_t;
`endif
  state_t state_q, state_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CNT_W-1:0] halt_count_q, halt_count_d;
  logic halt_req_q, halt_req_d, run_en_q, run_en_d, halted_q, halted_d;
  logic timeout_err_q, timeout_err_d;
  logic halt_press, step_d;
  cpu_halt_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_halt_db (
    .clk(clk), .rst(rst), .raw(halt_button), .press(halt_press)
  );
`ifdef SINGLE_STEP_EN
  logic step_press;
  cpu_halt_ctrl_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk(clk), .rst(rst), .raw(step_button), .press(step_press)
  );
  assign step_d = (state_d == STEP);
`else
  logic unused_step;
  assign unused_step = ^{step_button, instr_retired};
  assign step_d = 1'b0;
`endif
  // next state, timeout counting, halt counting and sticky timeout flag
  always_comb begin
    state_d = state_q;
    tcnt_d = tcnt_q;
    halt_count_d = halt_count_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      RUN: if (halt_press) begin
        state_d = HALT_REQ;
        tcnt_d = '0;
      end
      HALT_REQ: if (cpu_halt_ack || tcnt_q == TW'(ACK_TIMEOUT - 1)) begin
        state_d = HALTED;
        halt_count_d = halt_count_q + CNT_W'(1);
        timeout_err_d = timeout_err_q | ~cpu_halt_ack;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
      HALTED: begin
        if (halt_press) state_d = RESUME;
`ifdef SINGLE_STEP_EN
        else if (step_press) state_d = STEP;
`endif
      end
      RESUME: state_d = RUN;
`ifdef SINGLE_STEP_EN
      STEP: if (instr_retired) state_d = HALTED;
`endif
      default: state_d = RUN;
    endcase
  end
  assign run_en_d = (state_d != HALTED);
  assign halt_req_d = (state_d == HALT_REQ) || step_d;
  assign halted_d = (state_d == HALTED) || step_d;
  // state and registered outputs; reset forces RUN with the CPU free to run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      tcnt_q <= '0;
      halt_count_q <= '0;
      timeout_err_q <= 1'b0;
      halt_req_q <= 1'b0;
      run_en_q <= 1'b1;
      halted_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q <= tcnt_d;
      halt_count_q <= halt_count_d;
      timeout_err_q <= timeout_err_d;
      halt_req_q <= halt_req_d;
      run_en_q <= run_en_d;
      halted_q <= halted_d;
    end
  end
  assign cpu_halt_req = halt_req_q;
  assign cpu_run_en = run_en_q;
  assign halted = halted_q;
  assign timeout_err = timeout_err_q;
  assign halt_count = halt_count_q;
endmodule

// File: tb/tb_cpu_halt_ctrl.sv
// tb_cpu_halt_ctrl: directed scenarios plus randomized traffic against a behavioural model
`timescale 1ns/1ps
module tb_cpu_halt_ctrl;
  localparam int D = 4, A = 8, W = 8, HMAX = 20000;
  localparam int M_RUN = 0, M_REQ = 1, M_HALT = 2, M_RES = 3, M_STEP = 4;
`ifdef SINGLE_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic halt_button = 1'b0, step_button = 1'b0, cpu_halt_ack = 1'b0, instr_retired = 1'b0;
  logic cpu_halt_req, cpu_run_en, halted, timeout_err;
  logic [W-1:0] halt_count;
  int n_checks = 0, n_fail = 0;
  int m_st, m_wait, m_cnt, t = 0, t0 = 0;
  bit m_err;
  bit hist [2][HMAX];
  bit db [2];
  int run_len [2], rose_at [2];

  cpu_halt_ctrl #(.DEBOUNCE_CYCLES(D), .ACK_TIMEOUT(A), .CNT_W(W)) dut (
    .clk(clk), .rst(rst), .halt_button(halt_button), .step_button(step_button),
    .cpu_halt_ack(cpu_halt_ack), .instr_retired(instr_retired),
    .cpu_halt_req(cpu_halt_req), .cpu_run_en(cpu_run_en), .halted(halted),
    .timeout_err(timeout_err), .halt_count(halt_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st = M_RUN; m_wait = 0; m_cnt = 0; m_err = 1'b0; t0 = t;
    for (int b = 0; b < 2; b++) begin
      db[b] = 1'b0; run_len[b] = 0; rose_at[b] = -100;
    end
  endtask

  // one clock edge of the reference: button history -> debounced level -> press -> run/halt rules
  task automatic model_step();
    bit hp, sp, lvl;
    t++;
    hist[0][t] = halt_button;
    hist[1][t] = step_button;
    hp = (rose_at[0] == t - 2);
    sp = (rose_at[1] == t - 2);
    for (int b = 0; b < 2; b++) begin
      lvl = (t - t0 >= 3) ? hist[b][t-2] : 1'b0;
      if (lvl == db[b]) run_len[b] = 0;
      else begin
        run_len[b] = run_len[b] + 1;
        if (run_len[b] == D) begin
          db[b] = lvl; run_len[b] = 0;
          if (lvl) rose_at[b] = t;
        end
      end
    end
    case (m_st)
      M_RUN: if (hp) begin m_st = M_REQ; m_wait = 0; end
      M_REQ: begin
        m_wait++;
        if (cpu_halt_ack || m_wait == A) begin
          if (!cpu_halt_ack) m_err = 1'b1;
          m_st = M_HALT;
          m_cnt = (m_cnt + 1) % (1 << W);
        end
      end
      M_HALT: if (hp) m_st = M_RES; else if (STEP_EN && sp) m_st = M_STEP;
      M_RES: m_st = M_RUN;
      M_STEP: if (instr_retired) m_st = M_HALT;
      default: ;
    endcase
  endtask

  task automatic cycle(input bit hb, input bit sb, input bit ack, input bit ret);
    halt_button = hb; step_button = sb; cpu_halt_ack = ack; instr_retired = ret;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("run_en", cpu_run_en, m_st != M_HALT);
    check("halt_req", cpu_halt_req, m_st == M_REQ || m_st == M_STEP);
    check("halted", halted, m_st == M_HALT || m_st == M_STEP);
    check("timeout_err", timeout_err, m_err);
    check("halt_count", halt_count, m_cnt);
  endtask

  task automatic press(input int hold, input bit ack);
    for (int i = 0; i < hold; i++) cycle(1'b1, 1'b0, ack, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, ack, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_run_en"}, cpu_run_en, 1);
    check({tag, "_halt_req"}, cpu_halt_req, 0);
    check({tag, "_halted"}, halted, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_halt_count"}, halt_count, 0);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_reset_vals("async_rst");
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit hb_r, sb_r;
    m_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    check_reset_vals("reset");
    for (int i = 0; i < 10; i++) cycle(i % 2 == 0, 1'b0, 1'b0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    check("bounce_req", cpu_halt_req, 0);
    check("bounce_run", cpu_run_en, 1);
    for (int i = 1; i <= 11; i++) begin
      cycle(i <= 10, 1'b0, i == 11, 1'b0);
      if (i == 7) check("req_before_lat", cpu_halt_req, 0);
      if (i == 8) check("req_at_lat", cpu_halt_req, 1);
    end
    check("ack_run_en", cpu_run_en, 0);
    check("ack_halted", halted, 1);
    check("ack_count", halt_count, 1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
`ifdef SINGLE_STEP_EN
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 8) begin
        check("step_run_en", cpu_run_en, 1);
        check("step_halted", halted, 1);
        check("step_req", cpu_halt_req, 1);
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    check("step_done_run_en", cpu_run_en, 0);
    check("step_done_count", halt_count, 1);
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
`endif
    for (int i = 1; i <= 9; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 7) check("resume_pre_run_en", cpu_run_en, 0);
      if (i == 8) begin
        check("resume_run_en", cpu_run_en, 1);
        check("resume_halted", halted, 0);
      end
      if (i == 9) check("resume_req", cpu_halt_req, 0);
    end
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 16; i++) begin
      cycle(i <= 10, 1'b0, 1'b0, 1'b0);
      if (i == 8) check("to_req", cpu_halt_req, 1);
      if (i == 15) check("to_not_yet", halted, 0);
      if (i == 16) begin
        check("to_halted", halted, 1);
        check("to_err", timeout_err, 1);
        check("to_count", halt_count, 2);
      end
    end
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    press(9, 1'b0);
    check("err_sticky", timeout_err, 1);
    check("err_sticky_run", cpu_run_en, 1);
    press(9, 1'b1);
    check("second_ack_count", halt_count, 3);
    press(9, 1'b0);
    for (int i = 1; i <= 10; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_req", cpu_halt_req, 1);
    async_reset();
    repeat (8) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 256; k++) begin
      press(9, 1'b1);
      if (k == 255) check("count_max", halt_count, 255);
      press(9, 1'b0);
    end
    check("count_wrap", halt_count, 0);
    hb_r = 1'b0; sb_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) hb_r = ~hb_r;
      if ($urandom_range(0, 9) == 0) sb_r = ~sb_r;
      if ($urandom_range(0, 999) == 0) async_reset();
      cycle(hb_r ^ ($urandom_range(0, 15) == 0), sb_r, $urandom_range(0, 5) == 0,
            $urandom_range(0, 3) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
